// File: rtl/otbn_pq_loop_ctrl_if.sv
// otbn_pq_loop_ctrl_if: strobe, ISPR access and operand-selector bundle
// between the PQ decoder (master) and the loop-index controller (slave).
interface otbn_pq_loop_ctrl_if #(
  parameter int PQLEN = 32,
  parameter int IdxW  = 8
);
  logic              insn_valid_i;
  logic              sl_m_i;
  logic              sl_j2_i;
  logic              inc_j_i;
  logic              inc_idx_i;
  logic              set_idx_i;
  logic              omega_idx_inc_i;
  logic              psi_idx_inc_i;
  logic              ispr_wr_en_i;
  logic [3:0]        ispr_addr_i;
  logic [PQLEN-1:0]  ispr_wdata_i;
  logic [PQLEN-1:0]  ispr_rdata_o;
  logic [2:0]        op_a_w_sel_o;
  logic [2:0]        op_b_w_sel_o;
  logic [IdxW-4:0]   op_a_wdr_off_o;
  logic [IdxW-4:0]   op_b_wdr_off_o;
  logic [2:0]        omega_idx_o;
  logic [2:0]        psi_idx_o;
  logic [PQLEN-1:0]  mode_o;
  logic              j_wrap_o;
  logic              idx_wrap_o;

  modport master (
    output insn_valid_i, sl_m_i, sl_j2_i, inc_j_i, inc_idx_i, set_idx_i,
           omega_idx_inc_i, psi_idx_inc_i, ispr_wr_en_i, ispr_addr_i, ispr_wdata_i,
    input  ispr_rdata_o, op_a_w_sel_o, op_b_w_sel_o, op_a_wdr_off_o, op_b_wdr_off_o,
           omega_idx_o, psi_idx_o, mode_o, j_wrap_o, idx_wrap_o
  );

  modport slave (
    input  insn_valid_i, sl_m_i, sl_j2_i, inc_j_i, inc_idx_i, set_idx_i,
           omega_idx_inc_i, psi_idx_inc_i, ispr_wr_en_i, ispr_addr_i, ispr_wdata_i,
    output ispr_rdata_o, op_a_w_sel_o, op_b_w_sel_o, op_a_wdr_off_o, op_b_wdr_off_o,
           omega_idx_o, psi_idx_o, mode_o, j_wrap_o, idx_wrap_o
  );
endinterface

// File: rtl/otbn_pq_loop_ctrl.sv
// otbn_pq_loop_ctrl: NTT/INTT loop-index controller for the OTBN PQ extension.
// Holds M, J2, J, Idx0, Idx1, Mode, OmegaIdx, PsiIdx and derives the operand
// word selectors / WDR offsets from Idx0 and Idx1.
// Optional feature macro: OTBN_PQ_IDX_SKIP_EN -- when defined, inc_idx jumps
// over the partner half of a butterfly block using the internal counter K.
module otbn_pq_loop_ctrl #(
  parameter int NofCoeffs = 256,
  parameter int PQLEN     = 32,
  parameter int IdxW      = $clog2(NofCoeffs)
) (
  input logic                clk_i,
  input logic                rst_i,
  otbn_pq_loop_ctrl_if.slave bus
);

  localparam int SumW = PQLEN + 1;
  localparam logic [PQLEN-1:0] OneP    = {{(PQLEN-1){1'b0}}, 1'b1};
  localparam logic [SumW-1:0]  OneS    = {{(SumW-1){1'b0}}, 1'b1};
  localparam logic [SumW-1:0]  NCoeffS = SumW'(NofCoeffs);

  logic [PQLEN-1:0] m_r, j2_r, j_r, mode_r;
  logic [IdxW-1:0]  idx0_r, idx1_r;
  logic [2:0]       omega_r, psi_r;
  logic             j_wrap_r, idx_wrap_r;

  logic [PQLEN-1:0] m_nxt_s, j2_nxt_s, j_nxt_s, mode_nxt_s, j_inc_s;
  logic [IdxW-1:0]  idx0_nxt_s, idx1_nxt_s, idx0_upd_s, idx1_upd_s, idx0_sum_s;
  logic [SumW-1:0]  idx_step_s, idx1_sum_s;
  logic [2:0]       omega_nxt_s, psi_nxt_s;
  logic             j_wrap_s, idx_wrap_s;

`ifdef OTBN_PQ_IDX_SKIP_EN
  logic [IdxW-1:0]  k_r, k_nxt_s, k_upd_s;
  logic [PQLEN-1:0] k_inc_s;
  logic             blk_end_s;
`endif

  // Strobes and writes only count while the instruction is valid.
  logic sl_m_s, sl_j2_s, inc_j_s, inc_idx_s, set_idx_s, omega_inc_s, psi_inc_s, wr_s;
  assign sl_m_s      = bus.insn_valid_i & bus.sl_m_i;
  assign sl_j2_s     = bus.insn_valid_i & bus.sl_j2_i;
  assign inc_j_s     = bus.insn_valid_i & bus.inc_j_i;
  assign inc_idx_s   = bus.insn_valid_i & bus.inc_idx_i;
  assign set_idx_s   = bus.insn_valid_i & bus.set_idx_i;
  assign omega_inc_s = bus.insn_valid_i & bus.omega_idx_inc_i;
  assign psi_inc_s   = bus.insn_valid_i & bus.psi_idx_inc_i;
  assign wr_s        = bus.insn_valid_i & bus.ispr_wr_en_i;

  logic wr_omega_s, wr_psi_s, wr_m_s, wr_j2_s, wr_j_s, wr_idx0_s, wr_idx1_s, wr_mode_s;
  assign wr_omega_s = wr_s & (bus.ispr_addr_i == 4'd5);
  assign wr_psi_s   = wr_s & (bus.ispr_addr_i == 4'd6);
  assign wr_m_s     = wr_s & (bus.ispr_addr_i == 4'd8);
  assign wr_j2_s    = wr_s & (bus.ispr_addr_i == 4'd9);
  assign wr_j_s     = wr_s & (bus.ispr_addr_i == 4'd10);
  assign wr_idx0_s  = wr_s & (bus.ispr_addr_i == 4'd11);
  assign wr_idx1_s  = wr_s & (bus.ispr_addr_i == 4'd12);
  assign wr_mode_s  = wr_s & (bus.ispr_addr_i == 4'd13);

`ifdef OTBN_PQ_IDX_SKIP_EN
  // Index step: skip the partner half (J2+1) at the last butterfly of a block.
  always_comb begin
    k_inc_s   = {{(PQLEN-IdxW){1'b0}}, k_r} + OneP;
    blk_end_s = (k_inc_s == j2_r);
    if (blk_end_s) begin
      idx_step_s = {1'b0, j2_r} + OneS;
    end else begin
      idx_step_s = OneS;
    end
  end
`else
  assign idx_step_s = OneS;
`endif

  // Wide Idx1 sum so running past NofCoeffs is visible before truncation.
  assign idx1_sum_s = {{(SumW-IdxW){1'b0}}, idx1_r} + idx_step_s;
  assign idx0_sum_s = idx0_r + idx_step_s[IdxW-1:0];
  assign idx_wrap_s = inc_idx_s & ~set_idx_s & (idx1_sum_s >= NCoeffS);
  assign j_inc_s    = j_r + OneP;
  assign j_wrap_s   = inc_j_s & (j_inc_s == m_r);

  // Next-state: strobe updates from pre-cycle values, ISPR writes override per register.
  always_comb begin
    m_nxt_s     = m_r;
    j2_nxt_s    = j2_r;
    j_nxt_s     = j_r;
    mode_nxt_s  = mode_r;
    omega_nxt_s = omega_r;
    psi_nxt_s   = psi_r;
    idx0_upd_s  = idx0_r;
    idx1_upd_s  = idx1_r;
`ifdef OTBN_PQ_IDX_SKIP_EN
    k_upd_s     = k_r;
`endif

    if (wr_m_s) begin
      m_nxt_s = bus.ispr_wdata_i;
    end else if (sl_m_s) begin
      m_nxt_s = {m_r[PQLEN-2:0], 1'b0};
    end else begin
      m_nxt_s = m_r;
    end

    if (wr_j2_s) begin
      j2_nxt_s = bus.ispr_wdata_i;
    end else if (sl_j2_s) begin
      j2_nxt_s = {j2_r[PQLEN-2:0], 1'b0};
    end else begin
      j2_nxt_s = j2_r;
    end

    if (wr_j_s) begin
      j_nxt_s = bus.ispr_wdata_i;
    end else if (inc_j_s) begin
      j_nxt_s = j_wrap_s ? {PQLEN{1'b0}} : j_inc_s;
    end else begin
      j_nxt_s = j_r;
    end

    if (wr_mode_s) begin
      mode_nxt_s = bus.ispr_wdata_i;
    end else begin
      mode_nxt_s = mode_r;
    end

    if (wr_omega_s) begin
      omega_nxt_s = bus.ispr_wdata_i[2:0];
    end else if (omega_inc_s) begin
      omega_nxt_s = omega_r + 3'd1;
    end else begin
      omega_nxt_s = omega_r;
    end

    if (wr_psi_s) begin
      psi_nxt_s = bus.ispr_wdata_i[2:0];
    end else if (psi_inc_s) begin
      psi_nxt_s = psi_r + 3'd1;
    end else begin
      psi_nxt_s = psi_r;
    end

    // set_idx and an index wrap both reload the block start from old J2.
    if (set_idx_s || idx_wrap_s) begin
      idx0_upd_s = {IdxW{1'b0}};
      idx1_upd_s = j2_r[IdxW-1:0];
`ifdef OTBN_PQ_IDX_SKIP_EN
      k_upd_s    = {IdxW{1'b0}};
`endif
    end else if (inc_idx_s) begin
      idx0_upd_s = idx0_sum_s;
      idx1_upd_s = idx1_sum_s[IdxW-1:0];
`ifdef OTBN_PQ_IDX_SKIP_EN
      k_upd_s    = blk_end_s ? {IdxW{1'b0}} : k_inc_s[IdxW-1:0];
`endif
    end else begin
      idx0_upd_s = idx0_r;
      idx1_upd_s = idx1_r;
`ifdef OTBN_PQ_IDX_SKIP_EN
      k_upd_s    = k_r;
`endif
    end

    idx0_nxt_s = wr_idx0_s ? bus.ispr_wdata_i[IdxW-1:0] : idx0_upd_s;
    idx1_nxt_s = wr_idx1_s ? bus.ispr_wdata_i[IdxW-1:0] : idx1_upd_s;
  end

`ifdef OTBN_PQ_IDX_SKIP_EN
  // Any software write to an index register restarts the block counter.
  assign k_nxt_s = (wr_idx0_s | wr_idx1_s) ? {IdxW{1'b0}} : k_upd_s;
`endif

  // State register with synchronous reset; reset drops same-cycle strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_r        <= OneP;
      j2_r       <= OneP;
      j_r        <= {PQLEN{1'b0}};
      mode_r     <= {PQLEN{1'b0}};
      idx0_r     <= {IdxW{1'b0}};
      idx1_r     <= {{(IdxW-1){1'b0}}, 1'b1};
      omega_r    <= 3'd0;
      psi_r      <= 3'd0;
      j_wrap_r   <= 1'b0;
      idx_wrap_r <= 1'b0;
`ifdef OTBN_PQ_IDX_SKIP_EN
      k_r        <= {IdxW{1'b0}};
`endif
    end else begin
      m_r        <= m_nxt_s;
      j2_r       <= j2_nxt_s;
      j_r        <= j_nxt_s;
      mode_r     <= mode_nxt_s;
      idx0_r     <= idx0_nxt_s;
      idx1_r     <= idx1_nxt_s;
      omega_r    <= omega_nxt_s;
      psi_r      <= psi_nxt_s;
      j_wrap_r   <= j_wrap_s;
      idx_wrap_r <= idx_wrap_s;
`ifdef OTBN_PQ_IDX_SKIP_EN
      k_r        <= k_nxt_s;
`endif
    end
  end

  // ISPR read mux; index registers are zero-extended, unmapped addresses read 0.
  always_comb begin
    bus.ispr_rdata_o = {PQLEN{1'b0}};
    case (bus.ispr_addr_i)
      4'd5:    bus.ispr_rdata_o = {{(PQLEN-3){1'b0}}, omega_r};
      4'd6:    bus.ispr_rdata_o = {{(PQLEN-3){1'b0}}, psi_r};
      4'd8:    bus.ispr_rdata_o = m_r;
      4'd9:    bus.ispr_rdata_o = j2_r;
      4'd10:   bus.ispr_rdata_o = j_r;
      4'd11:   bus.ispr_rdata_o = {{(PQLEN-IdxW){1'b0}}, idx0_r};
      4'd12:   bus.ispr_rdata_o = {{(PQLEN-IdxW){1'b0}}, idx1_r};
      4'd13:   bus.ispr_rdata_o = mode_r;
      default: bus.ispr_rdata_o = {PQLEN{1'b0}};
    endcase
  end

  assign bus.op_a_w_sel_o   = idx0_r[2:0];
  assign bus.op_b_w_sel_o   = idx1_r[2:0];
  assign bus.op_a_wdr_off_o = idx0_r[IdxW-1:3];
  assign bus.op_b_wdr_off_o = idx1_r[IdxW-1:3];
  assign bus.omega_idx_o    = omega_r;
  assign bus.psi_idx_o      = psi_r;
  assign bus.mode_o         = mode_r;
  assign bus.j_wrap_o       = j_wrap_r;
  assign bus.idx_wrap_o     = idx_wrap_r;

endmodule

// File: tb/tb_otbn_pq_loop_ctrl.sv
// tb_otbn_pq_loop_ctrl: directed self-checking bench for otbn_pq_loop_ctrl
// (N=256, PQLEN=32). Expectations for inc_idx follow OTBN_PQ_IDX_SKIP_EN.
module tb_otbn_pq_loop_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  otbn_pq_loop_ctrl_if #(.PQLEN(32), .IdxW(8)) bus ();

  otbn_pq_loop_ctrl #(.NofCoeffs(256), .PQLEN(32), .IdxW(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.insn_valid_i    = 1'b0;
    bus.sl_m_i          = 1'b0;
    bus.sl_j2_i         = 1'b0;
    bus.inc_j_i         = 1'b0;
    bus.inc_idx_i       = 1'b0;
    bus.set_idx_i       = 1'b0;
    bus.omega_idx_inc_i = 1'b0;
    bus.psi_idx_inc_i   = 1'b0;
    bus.ispr_wr_en_i    = 1'b0;
    bus.ispr_wdata_i    = 32'd0;
  endtask

  // s bits: 0 sl_m, 1 sl_j2, 2 inc_j, 3 inc_idx, 4 set_idx, 5 omega_inc, 6 psi_inc
  task automatic go(input logic valid, input logic [6:0] s);
    bus.insn_valid_i    = valid;
    bus.sl_m_i          = s[0];
    bus.sl_j2_i         = s[1];
    bus.inc_j_i         = s[2];
    bus.inc_idx_i       = s[3];
    bus.set_idx_i       = s[4];
    bus.omega_idx_inc_i = s[5];
    bus.psi_idx_inc_i   = s[6];
    tick();
    clear_in();
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    bus.insn_valid_i = 1'b1;
    bus.ispr_wr_en_i = 1'b1;
    bus.ispr_addr_i  = addr;
    bus.ispr_wdata_i = data;
    tick();
    clear_in();
  endtask

  task automatic rd(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    bus.ispr_addr_i = addr;
    #1;
    check(tag, bus.ispr_rdata_o, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

`ifdef OTBN_PQ_IDX_SKIP_EN
  int exp_i0 [3] = '{1, 4, 5};
  int exp_i1 [3] = '{3, 6, 7};
`else
  int exp_i0 [3] = '{1, 2, 3};
  int exp_i1 [3] = '{3, 4, 5};
`endif

  initial begin
    clear_in();
    bus.ispr_addr_i = 4'd0;

    // Reset values
    do_reset();
    rd("rst_m",    4'd8,  32'd1);
    rd("rst_j2",   4'd9,  32'd1);
    rd("rst_j",    4'd10, 32'd0);
    rd("rst_idx0", 4'd11, 32'd0);
    rd("rst_idx1", 4'd12, 32'd1);
    rd("rst_mode", 4'd13, 32'd0);
    check("rst_jwrap",   {31'd0, bus.j_wrap_o},   32'd0);
    check("rst_idxwrap", {31'd0, bus.idx_wrap_o}, 32'd0);

    // J loop with M=4
    wr(4'd8, 32'd4);
    for (int i = 0; i < 4; i++) begin
      go(1'b1, 7'b0000100);
      rd($sformatf("jloop_j%0d", i), 4'd10, (i + 1) % 4);
      check($sformatf("jloop_wrap%0d", i), {31'd0, bus.j_wrap_o}, (i == 3) ? 32'd1 : 32'd0);
    end
    tick();
    check("jloop_wrap_end", {31'd0, bus.j_wrap_o}, 32'd0);

    // Block walk with J2=2
    wr(4'd9, 32'd2);
    go(1'b1, 7'b0010000);
    rd("set_idx0", 4'd11, 32'd0);
    rd("set_idx1", 4'd12, 32'd2);
    for (int i = 0; i < 3; i++) begin
      go(1'b1, 7'b0001000);
      rd($sformatf("walk_idx0_%0d", i), 4'd11, exp_i0[i]);
      rd($sformatf("walk_idx1_%0d", i), 4'd12, exp_i1[i]);
    end
    check("walk_b_sel", {29'd0, bus.op_b_w_sel_o},   32'(exp_i1[2]));
    check("walk_a_sel", {29'd0, bus.op_a_w_sel_o},   32'(exp_i0[2]));
    check("walk_b_off", {27'd0, bus.op_b_wdr_off_o}, 32'd0);

    // Index wrap at N=256
    wr(4'd9, 32'd1);
    wr(4'd12, 32'd255);
    go(1'b1, 7'b0001000);
    check("iwrap_pulse", {31'd0, bus.idx_wrap_o}, 32'd1);
    rd("iwrap_idx0", 4'd11, 32'd0);
    rd("iwrap_idx1", 4'd12, 32'd1);
    tick();
    check("iwrap_pulse_end", {31'd0, bus.idx_wrap_o}, 32'd0);

    // Offset field: Idx0 = 0x5d -> sel 5, off 11
    wr(4'd11, 32'h0000_015d);
    check("off_a_sel", {29'd0, bus.op_a_w_sel_o},   32'd5);
    check("off_a_off", {27'd0, bus.op_a_wdr_off_o}, 32'd11);

    // ISPR write vs sl_m on M; same-cycle read sees old value
    do_reset();
    bus.insn_valid_i = 1'b1;
    bus.ispr_wr_en_i = 1'b1;
    bus.ispr_addr_i  = 4'd8;
    bus.ispr_wdata_i = 32'd8;
    bus.sl_m_i       = 1'b1;
    #1;
    check("coll_m_old", bus.ispr_rdata_o, 32'd1);
    tick();
    clear_in();
    rd("coll_m_wr", 4'd8, 32'd8);

    // set_idx beats inc_idx
    wr(4'd9, 32'd4);
    go(1'b1, 7'b0001000);
    rd("pre_set_idx0", 4'd11, 32'd1);
    go(1'b1, 7'b0011000);
    rd("coll_set_idx0", 4'd11, 32'd0);
    rd("coll_set_idx1", 4'd12, 32'd4);

    // sl_m with inc_j at M=1, J=0: compare uses old M
    do_reset();
    go(1'b1, 7'b0000101);
    rd("coll_j", 4'd10, 32'd0);
    check("coll_jwrap", {31'd0, bus.j_wrap_o}, 32'd1);
    rd("coll_m_shift", 4'd8, 32'd2);

    // sl_j2 shift out loses bits
    wr(4'd9, 32'h8000_0000);
    go(1'b1, 7'b0000010);
    rd("j2_shift_out", 4'd9, 32'd0);

    // Mode and unmapped address
    wr(4'd13, 32'hA5A5_1234);
    check("mode_out", bus.mode_o, 32'hA5A5_1234);
    wr(4'd7, 32'hFFFF_FFFF);
    rd("unmapped", 4'd7, 32'd0);

    // Bank counters and invalid strobes
    for (int i = 0; i < 9; i++) go(1'b1, 7'b0100000);
    check("omega_9", {29'd0, bus.omega_idx_o}, 32'd1);
    check("psi_0",   {29'd0, bus.psi_idx_o},   32'd0);
    go(1'b0, 7'b1111111);
    check("inv_omega", {29'd0, bus.omega_idx_o}, 32'd1);
    check("inv_psi",   {29'd0, bus.psi_idx_o},   32'd0);
    rd("inv_j2", 4'd9, 32'd0);
    go(1'b1, 7'b1000000);
    rd("psi_rd", 4'd6, 32'd1);
    rd("omega_rd", 4'd5, 32'd1);

    // Reset mid-sequence drops the strobe in the reset cycle
    rst = 1'b1;
    go(1'b1, 7'b0000101);
    rst = 1'b0;
    rd("rst_mid_m", 4'd8, 32'd1);
    check("rst_mid_jwrap", {31'd0, bus.j_wrap_o}, 32'd0);
    check("rst_mid_omega", {29'd0, bus.omega_idx_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
